// File: rtl/me_mv_collector_pkg.sv
// ---------------------------------------------------------------------------
// me_mv_collector_pkg
// Shared definitions for the motion-vector collector:
//   - default SAD / motion-vector widths
//   - FSM state encoding (IDLE=0, ACCUM=1)
//   - packed result record {mv_x, mv_y, sad} at the default widths
// ---------------------------------------------------------------------------
package me_mv_collector_pkg;

   localparam int SAD_BIT_WIDTH_DEF = 14;
   localparam int MV_BIT_WIDTH_DEF  = 5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

   typedef struct packed {
      logic signed [MV_BIT_WIDTH_DEF-1:0] mv_x;
      logic signed [MV_BIT_WIDTH_DEF-1:0] mv_y;
      logic        [SAD_BIT_WIDTH_DEF-1:0] sad;
   } mv_result_t;

endpackage

// File: rtl/me_mv_collector_fifo.sv
// ---------------------------------------------------------------------------
// mv_result_fifo
// Two-entry synchronous FIFO with a registered head and valid/ready output.
// A push while full is only accepted when the head is popped in the same
// cycle; otherwise the pushed word is discarded (the owner flags that).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i            write strobe
//   push_data_i       write data
//   valid_o, ready_i  head handshake (pop on valid_o & ready_i)
//   data_o            registered head word
//   full_o            both entries occupied
// ---------------------------------------------------------------------------
module mv_result_fifo #(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o
);

   logic [DATA_W-1:0] head_r;
   logic [DATA_W-1:0] tail_r;
   logic [1:0]        count_r;
   logic              valid_r;
   logic              pop_s;

   assign pop_s   = valid_r & ready_i;
   assign valid_o = valid_r;
   assign data_o  = head_r;
   assign full_o  = (count_r == 2'd2);

   // Occupancy, head and tail storage update.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= 2'd0;
         valid_r <= 1'b0;
      end else begin
         case (count_r)
            2'd0: begin
               if (push_i) begin
                  head_r  <= push_data_i;
                  count_r <= 2'd1;
                  valid_r <= 1'b1;
               end
            end
            2'd1: begin
               if (push_i && pop_s) begin
                  head_r <= push_data_i;
               end else if (push_i) begin
                  tail_r  <= push_data_i;
                  count_r <= 2'd2;
               end else if (pop_s) begin
                  count_r <= 2'd0;
                  valid_r <= 1'b0;
               end
            end
            2'd2: begin
               // Full: a push only lands if the head leaves this cycle.
               if (pop_s) begin
                  head_r <= tail_r;
                  if (push_i) begin
                     tail_r <= push_data_i;
                  end else begin
                     count_r <= 2'd1;
                  end
               end
            end
            default: begin
               count_r <= 2'd0;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/me_mv_collector.sv
// ---------------------------------------------------------------------------
// me_mv_collector
// Reduces the ME core's per-row interim minima of one 8x8 block into a single
// minimum SAD, converts the winning (row, column) offset into a signed motion
// vector and queues {mv_x, mv_y, sad} in a 2-entry valid/ready FIFO. The input
// is never stalled; a dropped result sets overflow_o, a restarted block sets
// abort_o (both sticky until rst).
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   sad_valid_i, block_start_i         interim batch strobe / first batch
//   MSAD_interim, MSAD_index_interim   batch minimum SAD and its column
//   mv_valid_o, mv_ready_i             result queue head handshake
//   mv_x_o, mv_y_o, mv_sad_o           head result
//   block_cnt_o                        completed blocks (wraps)
//   overflow_o, abort_o                sticky status flags
// ---------------------------------------------------------------------------
module me_mv_collector
   import me_mv_collector_pkg::*;
#(
   parameter int SAD_BIT_WIDTH     = SAD_BIT_WIDTH_DEF,
   parameter int BATCHES_PER_BLOCK = 16,
   parameter int SEARCH_RANGE      = 8,
   parameter int MV_BIT_WIDTH      = MV_BIT_WIDTH_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            sad_valid_i,
   input  logic                            block_start_i,
   input  logic [SAD_BIT_WIDTH-1:0]        MSAD_interim,
   input  logic [3:0]                      MSAD_index_interim,
   output logic                            mv_valid_o,
   input  logic                            mv_ready_i,
   output logic signed [MV_BIT_WIDTH-1:0]  mv_x_o,
   output logic signed [MV_BIT_WIDTH-1:0]  mv_y_o,
   output logic [SAD_BIT_WIDTH-1:0]        mv_sad_o,
   output logic [15:0]                     block_cnt_o,
   output logic                            overflow_o,
   output logic                            abort_o
);

   localparam int CNT_W = (BATCHES_PER_BLOCK > 1) ? $clog2(BATCHES_PER_BLOCK) : 1;
   localparam int RES_W = 2 * MV_BIT_WIDTH + SAD_BIT_WIDTH;
   localparam logic [CNT_W-1:0] LAST_BATCH = CNT_W'(BATCHES_PER_BLOCK - 1);

   state_e                   state_r;
   logic [CNT_W-1:0]         batch_cnt_r;
   logic [SAD_BIT_WIDTH-1:0] best_sad_r;
   logic [3:0]               best_x_r;
   logic [CNT_W-1:0]         best_y_r;
   logic [15:0]              block_cnt_r;
   logic                     overflow_r;
   logic                     abort_r;

   logic                     start_s;
   logic                     accum_s;
   logic                     done_s;
   logic                     abort_s;
   logic                     drop_s;
   logic [SAD_BIT_WIDTH-1:0] nxt_sad_s;
   logic [3:0]               nxt_x_s;
   logic [CNT_W-1:0]         nxt_y_s;
   logic [CNT_W-1:0]         nxt_cnt_s;
   logic [MV_BIT_WIDTH-1:0]  mv_x_s;
   logic [MV_BIT_WIDTH-1:0]  mv_y_s;
   logic [RES_W-1:0]         push_data_s;
   logic [RES_W-1:0]         head_s;
   logic                     full_s;

   // Fold the current batch into the running best; the final batch's result
   // is taken from these next-state values so it is compared before pushing.
   always_comb begin
      start_s   = sad_valid_i & block_start_i;
      accum_s   = sad_valid_i & ~block_start_i & (state_r == ST_ACCUM);
      nxt_sad_s = best_sad_r;
      nxt_x_s   = best_x_r;
      nxt_y_s   = best_y_r;
      nxt_cnt_s = batch_cnt_r;
      done_s    = 1'b0;
      abort_s   = 1'b0;
      if (start_s) begin
         nxt_sad_s = MSAD_interim;
         nxt_x_s   = MSAD_index_interim;
         nxt_y_s   = '0;
         nxt_cnt_s = CNT_W'(1);
         done_s    = (BATCHES_PER_BLOCK == 1);
         abort_s   = (state_r == ST_ACCUM);
      end else if (accum_s) begin
         // Strict compare: ties keep the earlier row.
         if (MSAD_interim < best_sad_r) begin
            nxt_sad_s = MSAD_interim;
            nxt_x_s   = MSAD_index_interim;
            nxt_y_s   = batch_cnt_r;
         end else begin
            nxt_sad_s = best_sad_r;
         end
         nxt_cnt_s = batch_cnt_r + CNT_W'(1);
         done_s    = (batch_cnt_r == LAST_BATCH);
      end else begin
         done_s = 1'b0;
      end
   end

   // Biased offsets to two's complement vectors, packed as {mv_x, mv_y, sad}.
   always_comb begin
      mv_x_s      = MV_BIT_WIDTH'(nxt_x_s) - MV_BIT_WIDTH'(SEARCH_RANGE);
      mv_y_s      = MV_BIT_WIDTH'(nxt_y_s) - MV_BIT_WIDTH'(SEARCH_RANGE);
      push_data_s = {mv_x_s, mv_y_s, nxt_sad_s};
      drop_s      = done_s & full_s & ~(mv_valid_o & mv_ready_i);
   end

   // Block accumulation FSM, completion counter and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         batch_cnt_r <= '0;
         best_sad_r  <= '0;
         best_x_r    <= 4'd0;
         best_y_r    <= '0;
         block_cnt_r <= 16'd0;
         overflow_r  <= 1'b0;
         abort_r     <= 1'b0;
      end else begin
         if (start_s || accum_s) begin
            best_sad_r <= nxt_sad_s;
            best_x_r   <= nxt_x_s;
            best_y_r   <= nxt_y_s;
         end
         if (done_s) begin
            state_r     <= ST_IDLE;
            batch_cnt_r <= '0;
            block_cnt_r <= block_cnt_r + 16'd1;
         end else if (start_s || accum_s) begin
            state_r     <= ST_ACCUM;
            batch_cnt_r <= nxt_cnt_s;
         end
         if (abort_s) begin
            abort_r <= 1'b1;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   mv_result_fifo #(
      .DATA_W (RES_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (done_s),
      .push_data_i (push_data_s),
      .valid_o     (mv_valid_o),
      .ready_i     (mv_ready_i),
      .data_o      (head_s),
      .full_o      (full_s)
   );

   assign mv_x_o      = head_s[RES_W-1 -: MV_BIT_WIDTH];
   assign mv_y_o      = head_s[SAD_BIT_WIDTH +: MV_BIT_WIDTH];
   assign mv_sad_o    = head_s[SAD_BIT_WIDTH-1:0];
   assign block_cnt_o = block_cnt_r;
   assign overflow_o  = overflow_r;
   assign abort_o     = abort_r;

endmodule

// File: tb/tb_me_mv_collector.sv
// ---------------------------------------------------------------------------
// tb_me_mv_collector
// Self-checking bench: expected results are queued as blocks are driven and
// compared by a monitor whenever the DUT's head is accepted.
// ---------------------------------------------------------------------------
module tb_me_mv_collector;
   import me_mv_collector_pkg::*;

   logic              clk;
   logic              rst;
   logic              sad_valid_i;
   logic              block_start_i;
   logic [13:0]       MSAD_interim;
   logic [3:0]        MSAD_index_interim;
   logic              mv_valid_o;
   logic              mv_ready_i;
   logic signed [4:0] mv_x_o;
   logic signed [4:0] mv_y_o;
   logic [13:0]       mv_sad_o;
   logic [15:0]       block_cnt_o;
   logic              overflow_o;
   logic              abort_o;

   int         checks = 0;
   int         errors = 0;
   mv_result_t exp_q[$];
   mv_result_t mon_e;
   int         blk_sad[16];
   int         blk_idx[16];

   me_mv_collector dut (
      .clk                (clk),
      .rst                (rst),
      .sad_valid_i        (sad_valid_i),
      .block_start_i      (block_start_i),
      .MSAD_interim       (MSAD_interim),
      .MSAD_index_interim (MSAD_index_interim),
      .mv_valid_o         (mv_valid_o),
      .mv_ready_i         (mv_ready_i),
      .mv_x_o             (mv_x_o),
      .mv_y_o             (mv_y_o),
      .mv_sad_o           (mv_sad_o),
      .block_cnt_o        (block_cnt_o),
      .overflow_o         (overflow_o),
      .abort_o            (abort_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every accepted head must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && mv_valid_o && mv_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got x=%0d y=%0d sad=%0d, required no result", mv_x_o, mv_y_o, mv_sad_o);
         end else begin
            mon_e = exp_q.pop_front();
            if ({mv_x_o, mv_y_o, mv_sad_o} !== mon_e) begin
               errors++;
               $display("FAIL result: got x=%0d y=%0d sad=%0d, required x=%0d y=%0d sad=%0d",
                        mv_x_o, mv_y_o, mv_sad_o, mon_e.mv_x, mon_e.mv_y, mon_e.sad);
            end
         end
      end
   end

   // Reference reduction: first strict minimum over rows, biased by 8.
   function automatic mv_result_t model();
      mv_result_t r;
      int best, bx, by;
      best = blk_sad[0]; bx = blk_idx[0]; by = 0;
      for (int k = 1; k < 16; k++) begin
         if (blk_sad[k] < best) begin
            best = blk_sad[k]; bx = blk_idx[k]; by = k;
         end
      end
      r.mv_x = 5'(bx - 8);
      r.mv_y = 5'(by - 8);
      r.sad  = 14'(best);
      return r;
   endfunction

   task automatic drive_batch(input int sad, input int idx, input bit start);
      sad_valid_i        = 1'b1;
      block_start_i      = start;
      MSAD_interim       = 14'(sad);
      MSAD_index_interim = 4'(idx);
      @(posedge clk); #1;
      sad_valid_i   = 1'b0;
      block_start_i = 1'b0;
   endtask

   task automatic fill_random(input int lo, input int hi);
      for (int k = 0; k < 16; k++) begin
         blk_sad[k] = int'($urandom_range(hi, lo));
         blk_idx[k] = int'($urandom_range(15, 0));
      end
   endtask

   task automatic send_block(input bit gap, input bit push_exp);
      if (push_exp) exp_q.push_back(model());
      for (int k = 0; k < 16; k++) begin
         drive_batch(blk_sad[k], blk_idx[k], (k == 0));
         if (gap) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1; sad_valid_i = 1'b0; block_start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_empty(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; sad_valid_i = 1'b0; block_start_i = 1'b0;
      MSAD_interim = 14'd0; MSAD_index_interim = 4'd0; mv_ready_i = 1'b1;
      repeat (2) @(posedge clk); #1;
      checks += 4;
      if (mv_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", mv_valid_o); end
      if ({mv_x_o, mv_y_o, mv_sad_o} !== 24'd0) begin errors++; $display("FAIL reset_head: got %h, required 0", {mv_x_o, mv_y_o, mv_sad_o}); end
      if (block_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d, required 0", block_cnt_o); end
      if ({overflow_o, abort_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b, required 00", {overflow_o, abort_o}); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      mv_ready_i = 1'b1;
      for (int k = 0; k < 16; k++) begin
         blk_sad[k] = 1000 - 10 * k;
         blk_idx[k] = k % 16;
      end
      exp_q.push_back('{mv_x: 5'sd7, mv_y: 5'sd7, sad: 14'd850});
      for (int k = 0; k < 16; k++) begin
         drive_batch(blk_sad[k], blk_idx[k], (k == 0));
         if (k == 14) begin
            checks++;
            if (mv_valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b, required 0", mv_valid_o); end
         end
      end
      checks += 2;
      if (mv_valid_o !== 1'b1) begin errors++; $display("FAIL single_latency: got %b, required 1", mv_valid_o); end
      if ({mv_x_o, mv_y_o, mv_sad_o} !== {5'sd7, 5'sd7, 14'd850}) begin
         errors++; $display("FAIL single_head: got x=%0d y=%0d sad=%0d, required x=7 y=7 sad=850", mv_x_o, mv_y_o, mv_sad_o);
      end
      wait_empty(ok);
      checks += 2;
      if (!ok) begin errors++; $display("FAIL single_drain: got timeout, required drained"); end
      if (block_cnt_o !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d, required 1", block_cnt_o); end
   endtask

   task automatic test_tie();
      bit ok;
      for (int k = 0; k < 16; k++) begin
         blk_sad[k] = 500;
         blk_idx[k] = k;
      end
      blk_sad[3] = 200; blk_idx[3] = 2;
      blk_sad[9] = 200; blk_idx[9] = 5;
      exp_q.push_back('{mv_x: -5'sd6, mv_y: -5'sd5, sad: 14'd200});
      send_block(1'b0, 1'b0);
      wait_empty(ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL tie_drain: got timeout, required drained"); end
      if (block_cnt_o !== 16'd2) begin errors++; $display("FAIL tie_cnt: got %0d, required 2", block_cnt_o); end
      if ({overflow_o, abort_o} !== 2'b00) begin errors++; $display("FAIL tie_flags: got %b, required 00", {overflow_o, abort_o}); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      apply_reset();
      mv_ready_i = 1'b0;
      fill_random(100, 130); send_block(1'b0, 1'b1);
      fill_random(100, 130); send_block(1'b0, 1'b1);
      fill_random(100, 130); send_block(1'b0, 1'b0);
      checks += 4;
      if (overflow_o !== 1'b1) begin errors++; $display("FAIL b2b_overflow: got %b, required 1", overflow_o); end
      if (block_cnt_o !== 16'd3) begin errors++; $display("FAIL b2b_cnt: got %0d, required 3", block_cnt_o); end
      if (mv_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b, required 1", mv_valid_o); end
      if ({mv_x_o, mv_y_o, mv_sad_o} !== exp_q[0]) begin errors++; $display("FAIL b2b_head: got %h, required %h", {mv_x_o, mv_y_o, mv_sad_o}, exp_q[0]); end
      repeat (3) @(posedge clk); #1;
      checks++;
      if ({mv_x_o, mv_y_o, mv_sad_o} !== exp_q[0]) begin errors++; $display("FAIL b2b_stable: got %h, required %h", {mv_x_o, mv_y_o, mv_sad_o}, exp_q[0]); end
      mv_ready_i = 1'b1;
      wait_empty(ok);
      checks += 2;
      if (!ok) begin errors++; $display("FAIL b2b_drain: got timeout, required drained"); end
      if (mv_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b, required 0", mv_valid_o); end
   endtask

   task automatic test_full_push_pop();
      bit ok;
      apply_reset();
      mv_ready_i = 1'b0;
      fill_random(0, 16383); send_block(1'b0, 1'b1);
      fill_random(0, 16383); send_block(1'b0, 1'b1);
      fill_random(0, 16383);
      exp_q.push_back(model());
      for (int k = 0; k < 16; k++) begin
         if (k == 15) mv_ready_i = 1'b1;
         drive_batch(blk_sad[k], blk_idx[k], (k == 0));
      end
      wait_empty(ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL fullpp_drain: got timeout, required drained"); end
      if (overflow_o !== 1'b0) begin errors++; $display("FAIL fullpp_overflow: got %b, required 0", overflow_o); end
      if (block_cnt_o !== 16'd3) begin errors++; $display("FAIL fullpp_cnt: got %0d, required 3", block_cnt_o); end
   endtask

   task automatic test_abort();
      bit ok;
      apply_reset();
      mv_ready_i = 1'b1;
      for (int k = 0; k < 7; k++) drive_batch(5, 3, (k == 0));
      fill_random(100, 140);
      send_block(1'b0, 1'b1);
      checks++;
      if (abort_o !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b, required 1", abort_o); end
      wait_empty(ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL abort_drain: got timeout, required drained"); end
      if (block_cnt_o !== 16'd1) begin errors++; $display("FAIL abort_cnt: got %0d, required 1", block_cnt_o); end
      if (overflow_o !== 1'b0) begin errors++; $display("FAIL abort_overflow: got %b, required 0", overflow_o); end
   endtask

   task automatic test_idle_pulse();
      bit ok;
      apply_reset();
      mv_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive_batch(3, 1, 1'b0);
         @(posedge clk); #1;
      end
      checks += 2;
      if ({mv_valid_o, overflow_o, abort_o} !== 3'b000) begin errors++; $display("FAIL idle_flags: got %b, required 000", {mv_valid_o, overflow_o, abort_o}); end
      if (block_cnt_o !== 16'd0) begin errors++; $display("FAIL idle_cnt: got %0d, required 0", block_cnt_o); end
      fill_random(100, 130);
      send_block(1'b1, 1'b1);
      wait_empty(ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL gap_drain: got timeout, required drained"); end
      if (block_cnt_o !== 16'd1) begin errors++; $display("FAIL gap_cnt: got %0d, required 1", block_cnt_o); end
      if (abort_o !== 1'b0) begin errors++; $display("FAIL gap_abort: got %b, required 0", abort_o); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      apply_reset();
      mv_ready_i = 1'b0;
      fill_random(100, 130);
      send_block(1'b0, 1'b1);
      checks++;
      if (mv_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %b, required 1", mv_valid_o); end
      fill_random(0, 50);
      for (int k = 0; k < 10; k++) drive_batch(blk_sad[k], blk_idx[k], (k == 0));
      rst = 1'b1; sad_valid_i = 1'b1; block_start_i = 1'b0;
      MSAD_interim = 14'(blk_sad[10]); MSAD_index_interim = 4'(blk_idx[10]);
      @(posedge clk); #1;
      rst = 1'b0; sad_valid_i = 1'b0;
      exp_q.delete();
      checks += 3;
      if ({mv_valid_o, overflow_o, abort_o} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b, required 000", {mv_valid_o, overflow_o, abort_o}); end
      if ({mv_x_o, mv_y_o, mv_sad_o} !== 24'd0) begin errors++; $display("FAIL rstmid_head: got %h, required 0", {mv_x_o, mv_y_o, mv_sad_o}); end
      if (block_cnt_o !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d, required 0", block_cnt_o); end
      mv_ready_i = 1'b1;
      fill_random(100, 130);
      send_block(1'b0, 1'b1);
      wait_empty(ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL rstmid_drain: got timeout, required drained"); end
      if (block_cnt_o !== 16'd1) begin errors++; $display("FAIL rstmid_cnt2: got %0d, required 1", block_cnt_o); end
      if (abort_o !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got %b, required 0", abort_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_back_to_back();
      test_full_push_pop();
      test_abort();
      test_idle_pulse();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/me_mv_collector.md
# me_mv_collector

Downstream consumer of the motion-estimation core's per-cycle interim minimum stream (`MSAD_interim`, `MSAD_index_interim`). Each interim value is the best of 16 candidates in one search row. The block reduces all batches of one 8x8 block's search window to a single minimum SAD. It converts the winning batch/index pair into a signed motion vector and hands it out through a 2-entry valid/ready result queue. The ME core has no backpressure, so this block never stalls its input; overflow is flagged, not absorbed.

## Interface
- `SAD_BIT_WIDTH`, 14, width of SAD values
- `BATCHES_PER_BLOCK`, 16, interim batches per block (one per vertical offset)
- `SEARCH_RANGE`, 8, offset bias; mv = raw offset − SEARCH_RANGE
- `MV_BIT_WIDTH`, 5, signed width of each mv component
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `sad_valid_i` in 1: interim batch valid this cycle
- `block_start_i` in 1: qualifies the first batch of a block; only meaningful with `sad_valid_i`
- `MSAD_interim` in SAD_BIT_WIDTH: batch minimum SAD
- `MSAD_index_interim` in 4: column offset of the batch minimum (0..15)
- `mv_valid_o` out 1: result queue head valid
- `mv_ready_i` in 1: consumer accepts head when high with `mv_valid_o`
- `mv_x_o` out MV_BIT_WIDTH: signed horizontal vector
- `mv_y_o` out MV_BIT_WIDTH: signed vertical vector
- `mv_sad_o` out SAD_BIT_WIDTH: minimum SAD of the block
- `block_cnt_o` out 16: number of blocks completed, wraps at 2^16
- `overflow_o` out 1: sticky; a result was dropped because the queue was full
- `abort_o` out 1: sticky; a block restarted before completion

## Operation
- FSM states: IDLE and ACCUM.
- IDLE → ACCUM on `sad_valid_i & block_start_i`:
  - load best_sad = `MSAD_interim`, best_x = index, best_y = 0
  - set batch_cnt = 1
- In IDLE, `sad_valid_i` without `block_start_i` is ignored (no count, no flag).
- In ACCUM, each `sad_valid_i` without `block_start_i`:
  - if `MSAD_interim` < best_sad (strict), replace best_sad, best_x = index, best_y = batch_cnt
  - increment batch_cnt
  - ties keep the earlier candidate (lowest row, then the ME core's own intra-batch order)
- Completion: the batch with batch_cnt == BATCHES_PER_BLOCK−1 is folded in (the compare above is applied to it first). Then:
  - final result is pushed to the queue
  - FSM → IDLE
  - `block_cnt_o` increments
- `block_start_i` with `sad_valid_i` while in ACCUM:
  - set `abort_o`
  - discard the partial block, no push
  - reload from this batch as in IDLE; stay in ACCUM
- If BATCHES_PER_BLOCK == 1, every start batch completes immediately.
- Vector computation: mv_x = best_x − SEARCH_RANGE, mv_y = best_y − SEARCH_RANGE, in two's complement MV_BIT_WIDTH. Default range is −8..+7.
- Result queue: 2-entry FIFO holding {mv_x, mv_y, sad}.
  - Push with the queue full (and no pop in the same cycle): result dropped, `overflow_o` set, `block_cnt_o` still increments.
  - Push and pop in the same cycle while full: both succeed.
- Only `rst` clears the sticky flags.

## Timing
- Input sampled at posedge when `sad_valid_i` is high; back-to-back every cycle is supported.
- Result latency: `mv_valid_o` rises the cycle after the final batch is sampled, if the queue was empty.
- Pop occurs at a posedge with `mv_valid_o & mv_ready_i`. Outputs show the next entry on the following cycle, or `mv_valid_o` drops.
- Head outputs are registered and stable while `mv_valid_o & !mv_ready_i`.
- A new block may start the cycle after completion; there is no bubble.
- Reset values:
  - state IDLE, batch_cnt 0, best_* 0
  - queue empty, `mv_valid_o` 0, `mv_x_o`/`mv_y_o`/`mv_sad_o` 0
  - `block_cnt_o` 0, `overflow_o` 0, `abort_o` 0
- Reset mid-block discards the partial block and queue contents, with no flag set.

## Structure
- Shared package holds:
  - SAD_BIT_WIDTH and MV_BIT_WIDTH defaults
  - the FSM state encoding (IDLE=0, ACCUM=1)
  - the packed result type {mv_x, mv_y, sad}
- One sub-module: `mv_result_fifo`, a parameterized 2-entry synchronous FIFO with valid/ready out, full flag and a registered head.

## Test plan
- Single block, 16 batches with SAD 1000−10·k and index k%16:
  - minimum is 850 at batch 15, index 15
  - → mv_x=+7, mv_y=+7, sad=850, `mv_valid_o` one cycle after batch 15
- Tie: batches 3 and 9 both SAD 200 (others 500), indices 2 and 5 → mv_x=−6, mv_y=−5, sad=200.
- Three back-to-back blocks with `mv_ready_i`=0:
  - first two queued, third dropped
  - `overflow_o`=1, `block_cnt_o`=3
  - releasing ready yields results 1 and 2 in order
- `block_start_i` at batch 7 of a block:
  - `abort_o`=1, no result for the partial block
  - next result reflects only the 16 batches after the restart
- `sad_valid_i` pulses in IDLE without start → no state change and no flags. Gapped valid (every other cycle) still completes after 16 batches.
- Assert `rst` at batch 10 with one result queued → all outputs return to 0 next cycle; a subsequent full block produces correct results.
